// File: rtl/multicycle_control_if.sv
// Bus between the multicycle sequencer and the datapath/memory side.
// Handshake: mem_read / mem_write are requests; once raised they stay
// high and unchanged until a cycle in which mem_ready is also high, and
// that cycle is the one in which the transfer completes.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             error;
    logic             trap;

    // Sequencer side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_count, error, trap
    );

    // Datapath / memory side
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_count, error, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the 16-bit processor: FETCH/DECODE/EXECUTE/MEM/WB
// over one shared memory port and one ALU, with memory-timeout detection
// and a retired-instruction counter.
// Build option: define ILLEGAL_TRAP_EN to send opcodes 0101..1111 to a
// sticky TRAP state; otherwise they execute as R-type and trap stays 0.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_MEM = 4'd6,
        S_EXEC_R = 4'd7,
        S_WB_R   = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ERROR  = 4'd11
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = 4'd12
`endif
    } state_t;

    // Registered control word; 'fetch' marks the FETCH state so ir_write and
    // the PC increment can follow mem_ready within the same cycle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       fetch;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       error;
`ifdef ILLEGAL_TRAP_EN
        logic       trap;
`endif
    } ctl_t;

    state_t           state_q;
    state_t           next_state;
    ctl_t             ctl_q;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic             wait_hit;
    logic             retire;

    // Control word for the state being entered
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WR: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_WB_MEM: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_WB_R:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.alu_op = 2'b11; end
            S_ERROR:  c.error = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   c.trap = 1'b1;
`endif
            default:  ;
        endcase
        return c;
    endfunction

    assign wait_hit = (wait_cnt == WAIT_LIMIT);
    assign retire   = (state_q == S_WB_MEM) || (state_q == S_WB_R) ||
                      (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                      ((state_q == S_MEM_WR) && bus.mem_ready);

    // Next-state selection; a ready memory beats a timeout on the limit cycle
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  begin
                if (bus.mem_ready)  next_state = S_DECODE;
                else if (wait_hit)  next_state = S_ERROR;
            end
            S_DECODE: begin
                case (bus.opcode)
                    4'b0000: next_state = S_JUMP;
                    4'b0001: next_state = S_EXEC_R;
                    4'b0010,
                    4'b0011: next_state = S_ADDR;
                    4'b0100: next_state = S_BRANCH;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        next_state = S_TRAP;
`else
                        next_state = S_EXEC_R;
`endif
                    end
                endcase
            end
            S_ADDR:   next_state = (bus.opcode == 4'b0011) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  next_state = S_WB_MEM;
                else if (wait_hit)  next_state = S_ERROR;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)  next_state = S_FETCH;
                else if (wait_hit)  next_state = S_ERROR;
            end
            S_WB_MEM: next_state = S_FETCH;
            S_EXEC_R: next_state = S_WB_R;
            S_WB_R:   next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_ERROR:  next_state = S_ERROR;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   next_state = S_TRAP;
`endif
            default:  next_state = S_IDLE;
        endcase
    end

    // State, registered controls, wait counter and retire counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctl_q     <= '0;
            wait_cnt  <= 8'd0;
            instr_cnt <= '0;
        end else begin
            state_q <= next_state;
            ctl_q   <= decode(next_state);
            if ((next_state != state_q) &&
                ((next_state == S_FETCH) || (next_state == S_MEM_RD) || (next_state == S_MEM_WR)))
                wait_cnt <= 8'd0;
            else if (((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) &&
                     !bus.mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_write      = ctl_q.pc_write | (ctl_q.fetch & bus.mem_ready);
    assign bus.ir_write      = ctl_q.fetch & bus.mem_ready;
    assign bus.pc_write_cond = ctl_q.pc_write_cond;
    assign bus.mem_read      = ctl_q.mem_read;
    assign bus.mem_write     = ctl_q.mem_write;
    assign bus.iord          = ctl_q.iord;
    assign bus.reg_write     = ctl_q.reg_write;
    assign bus.reg_dst       = ctl_q.reg_dst;
    assign bus.mem_to_reg    = ctl_q.mem_to_reg;
    assign bus.alu_src_a     = ctl_q.alu_src_a;
    assign bus.alu_src_b     = ctl_q.alu_src_b;
    assign bus.alu_op        = ctl_q.alu_op;
    assign bus.pc_source     = ctl_q.pc_source;
    assign bus.error         = ctl_q.error;
    assign bus.state         = state_q;
    assign bus.instr_count   = instr_cnt;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap          = ctl_q.trap;
`else
    assign bus.trap          = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. An instruction-level model expands each
// planned instruction (opcode, fetch waits, memory waits) into the expected
// per-cycle trace of state code, control outputs and retire count.
// CNT_W is 4 here so the retire counter wraps within a short run.
module tb_multicycle_control;
    localparam int CNT_W = 4;
    localparam int WMAX  = 15;

    // Control-vector bit masks (order matches obs_ctl below)
    localparam logic [17:0] PCW  = 18'h20000;
    localparam logic [17:0] PCWC = 18'h10000;
    localparam logic [17:0] IRW  = 18'h08000;
    localparam logic [17:0] MR   = 18'h04000;
    localparam logic [17:0] MW   = 18'h02000;
    localparam logic [17:0] IORD = 18'h01000;
    localparam logic [17:0] RW   = 18'h00800;
    localparam logic [17:0] RDST = 18'h00400;
    localparam logic [17:0] M2R  = 18'h00200;
    localparam logic [17:0] ASA  = 18'h00100;
    localparam logic [17:0] ERR  = 18'h00002;
    localparam logic [17:0] TRP  = 18'h00001;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_ADDR = 4'd3;
    localparam logic [3:0] ST_MEMRD = 4'd4, ST_MEMWR = 4'd5, ST_WBMEM = 4'd6, ST_EXECR = 4'd7;
    localparam logic [3:0] ST_WBR = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_ERROR = 4'd11;
    localparam logic [3:0] ST_TRAP = 4'd12;

    typedef struct packed {
        logic [3:0]       st;
        logic [17:0]      ctl;
        logic [CNT_W-1:0] cnt;
        logic             rdy;
        logic [3:0]       op;
    } step_t;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.MEM_WAIT_MAX(WMAX), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [17:0] obs_ctl;
    assign obs_ctl = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
                      bus.mem_write, bus.iord, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                      bus.error, bus.trap};

    // ---------------- scoreboard ----------------
    step_t            exp_q[$];
    logic [CNT_W-1:0] model_cnt;
    int               total = 0;
    int               bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] f(input logic [17:0] flags, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] psrc);
        return flags | {10'b0, asb, aop, psrc, 2'b00};
    endfunction

    task automatic push(input logic [3:0] st, input logic [17:0] ctl, input logic rdy,
                        input logic [3:0] op);
        step_t e;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = model_cnt;
        e.rdy = rdy;
        e.op  = op;
        exp_q.push_back(e);
    endtask

    task automatic push_stuck(input logic [3:0] st, input logic [17:0] ctl, input logic [3:0] op);
        repeat (3) push(st, ctl, rbit(), op);
    endtask

    // Reference model: one instruction -> expected cycle trace.
    // A memory access waiting more than WMAX cycles ends in ERROR.
    task automatic plan_instr(input logic [3:0] op, input int fw, input int mw, output bit term);
        logic [17:0] fetch_c;
        logic [17:0] mem_c;
        logic [3:0]  mem_st;
        fetch_c = f(MR, 2'b01, 2'b00, 2'b00);
        term    = 1'b0;
        for (int i = 0; i < fw && i <= WMAX; i++) push(ST_FETCH, fetch_c, 1'b0, op);
        if (fw > WMAX) begin
            push_stuck(ST_ERROR, ERR, op);
            term = 1'b1;
            return;
        end
        push(ST_FETCH, fetch_c | IRW | PCW, 1'b1, op);
        push(ST_DECODE, f('0, 2'b11, 2'b00, 2'b00), rbit(), op);
        case (op)
            4'd0: push(ST_JUMP, f(PCW, 2'b00, 2'b11, 2'b10), rbit(), op);
            4'd4: push(ST_BRANCH, f(ASA | PCWC, 2'b00, 2'b01, 2'b01), rbit(), op);
            4'd2, 4'd3: begin
                push(ST_ADDR, f(ASA, 2'b10, 2'b00, 2'b00), rbit(), op);
                mem_c  = (op == 4'd2) ? (MR | IORD) : (MW | IORD);
                mem_st = (op == 4'd2) ? ST_MEMRD : ST_MEMWR;
                for (int i = 0; i < mw && i <= WMAX; i++) push(mem_st, mem_c, 1'b0, op);
                if (mw > WMAX) begin
                    push_stuck(ST_ERROR, ERR, op);
                    term = 1'b1;
                    return;
                end
                push(mem_st, mem_c, 1'b1, op);
                if (op == 4'd2) push(ST_WBMEM, RW | M2R, rbit(), op);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                if (op != 4'd1) begin
                    push_stuck(ST_TRAP, TRP, op);
                    term = 1'b1;
                    return;
                end
`endif
                push(ST_EXECR, f(ASA, 2'b00, 2'b10, 2'b00), rbit(), op);
                push(ST_WBR, RW | RDST, rbit(), op);
            end
        endcase
        model_cnt = model_cnt + 1'b1;
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1: drive, settle, compare, advance.
    task automatic run(input int n);
        step_t e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            bus.mem_ready = e.rdy;
            bus.opcode    = e.op;
            #1;
            check("state", 32'(bus.state), 32'(e.st));
            check("ctl", 32'(obs_ctl), 32'(e.ctl));
            check("count", 32'(bus.instr_count), 32'(e.cnt));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.mem_ready = rbit();
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ctl", 32'(obs_ctl), 32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n   = 1'b1;
        exp_q.delete();
        model_cnt = '0;
        push(ST_IDLE, '0, rbit(), 4'd0);
    endtask

    task automatic exec(input logic [3:0] op, input int fw, input int mw);
        bit term;
        plan_instr(op, fw, mw, term);
        run(exp_q.size());
        if (term) do_reset();
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        r = $urandom_range(0, 11);
        if (r < 10) return 4'(r % 5);
        return 4'($urandom_range(5, 15));
    endfunction

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r < 24) return 0;
        if (r < 36) return $urandom_range(1, 3);
        if (r < 38) return WMAX;
        if (r == 38) return WMAX - 1;
        return WMAX + 1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit               term;
        logic [3:0]       dir_ops[5];
        bus.opcode    = 4'd0;
        bus.mem_ready = 1'b0;
        model_cnt     = '0;
        dir_ops       = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        @(posedge clock);
        #1;
        do_reset();

        // Zero-wait back-to-back, one of each legal class
        foreach (dir_ops[i]) exec(dir_ops[i], 0, 0);
        // lw stalled 3 cycles in MEM_RD, sw ready on the 16th wait cycle
        exec(4'd2, 0, 3);
        exec(4'd3, 0, WMAX);
        // Fetch ready exactly on the limit cycle, then illegal opcode 1010
        exec(4'd1, WMAX, 0);
        exec(4'd10, 0, 0);
        // Timeouts in FETCH, MEM_RD, MEM_WR
        exec(4'd1, WMAX + 1, 0);
        exec(4'd2, 0, WMAX + 1);
        exec(4'd3, 0, WMAX + 1);

        // Counter wrap: 17 jumps from reset on a 4-bit counter
        do_reset();
        repeat (17) exec(4'd0, 0, 0);

        // Reset asserted while MEM_RD is waiting with mem_read high
        plan_instr(4'd2, 0, 6, term);
        run(6);
        do_reset();

        // Randomized instruction stream
        repeat (300) exec(rand_op(), rand_wait(), rand_wait());
        run(exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
